// File: rtl/riscv_alu_trace_buffer_if.sv
// Capture/control/readout bundle for riscv_alu_trace_buffer.
// master: the core tap + debug controller; slave: the trace buffer.
interface riscv_alu_trace_buffer_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int ALUOP_W = 4
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5*XLEN + ALUOP_W + 6;

    logic               cap_valid;
    logic [XLEN-1:0]    cap_pc;
    logic [XLEN-1:0]    cap_inst;
    logic [XLEN-1:0]    cap_a;
    logic [XLEN-1:0]    cap_b;
    logic [XLEN-1:0]    cap_result;
    logic [ALUOP_W-1:0] cap_aluop;
    logic               cap_regwr;
    logic               arm;
    logic               trig_pc_en;
    logic [XLEN-1:0]    trig_pc;
    logic               trig_res_en;
    logic [XLEN-1:0]    trig_res;
    logic [AW-1:0]      post_count;
    logic [1:0]         state;
    logic [AW:0]        count;
    logic               rd_valid;
    logic               rd_ready;
    logic [EW-1:0]      rd_data;

    modport master (
        output cap_valid, cap_pc, cap_inst, cap_a, cap_b, cap_result, cap_aluop, cap_regwr,
        output arm, trig_pc_en, trig_pc, trig_res_en, trig_res, post_count, rd_ready,
        input  state, count, rd_valid, rd_data
    );

    modport slave (
        input  cap_valid, cap_pc, cap_inst, cap_a, cap_b, cap_result, cap_aluop, cap_regwr,
        input  arm, trig_pc_en, trig_pc, trig_res_en, trig_res, post_count, rd_ready,
        output state, count, rd_valid, rd_data
    );
endinterface

// File: rtl/riscv_alu_trace_buffer.sv
// ALU-stage trace capture: circular buffer of retired-instruction records with a
// PC/result trigger, a post-trigger window and an oldest-first readout port.
// Optional feature: define TRACE_REGWRITE_FILTER_EN to record only RegWrite=1
// instructions (triggers still evaluate on every capture).
module riscv_alu_trace_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int ALUOP_W  = 4,
    parameter int POST_MAX = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    riscv_alu_trace_buffer_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5*XLEN + ALUOP_W + 6;
    localparam int POST_CLAMP = (POST_MAX > DEPTH-1) ? DEPTH-1 : POST_MAX;
    localparam logic [AW-1:0] POST_RST = AW'(POST_CLAMP);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ARMED = 2'b01;
    localparam logic [1:0] S_POST  = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [EW-1:0]  mem [DEPTH];

    logic [1:0]     state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [AW:0]    count_reg, count_next;
    logic [AW-1:0]  post_reg, post_next;
    logic           rd_valid_reg, rd_valid_next;
    logic [EW-1:0]  rd_data_reg;

    logic           trig_hit;
    logic           record_ok;
    logic           capturing;
    logic           cap_store;
    logic           rd_fire;
    logic [EW-1:0]  cap_entry;

    // Qualify the tap: trigger match, record filter and the packed entry.
    always_comb begin
        trig_hit  = bus.cap_valid &
                    ((bus.trig_pc_en  & (bus.cap_pc     == bus.trig_pc)) |
                     (bus.trig_res_en & (bus.cap_result == bus.trig_res)));
`ifdef TRACE_REGWRITE_FILTER_EN
        record_ok = bus.cap_regwr;
`else
        record_ok = 1'b1;
`endif
        capturing = ((state_reg == S_ARMED) || (state_reg == S_POST)) && bus.cap_valid && !bus.arm;
        cap_store = capturing && record_ok;
        rd_fire   = (state_reg == S_DONE) && rd_valid_reg && bus.rd_ready && !bus.arm;
        cap_entry = {bus.cap_pc, bus.cap_inst, bus.cap_a, bus.cap_b, bus.cap_result,
                     bus.cap_aluop, bus.cap_inst[11:7], bus.cap_regwr};
    end

    // Next-state logic: arm overrides everything; otherwise capture, trigger and readout.
    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        post_next   = post_reg;
        if (bus.arm) begin
            state_next  = S_ARMED;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            // post_count is AW bits wide, so it can never exceed DEPTH-1.
            post_next   = bus.post_count;
        end else begin
            if (cap_store) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
                if (count_reg == FULL) begin
                    // Full: the oldest entry is overwritten, so the read side follows.
                    rd_ptr_next = rd_ptr_reg + AW'(1);
                end else begin
                    count_next = count_reg + (AW+1)'(1);
                end
            end
            case (state_reg)
                S_ARMED: begin
                    if (capturing && trig_hit) begin
                        state_next = (post_reg == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (cap_store) begin
                        post_next = post_reg - AW'(1);
                        if (post_reg == AW'(1)) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_fire) begin
                        rd_ptr_next = rd_ptr_reg + AW'(1);
                        count_next  = count_reg - (AW+1)'(1);
                    end
                end
                default: ;
            endcase
        end
        // Data is only presented once the buffer has been frozen for a full cycle,
        // so the registered read never races the final capture write.
        rd_valid_next = (state_reg == S_DONE) && (state_next == S_DONE) && (count_next != '0);
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            post_reg     <= POST_RST;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            post_reg     <= post_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    // Trace storage write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (cap_store) begin
            mem[wr_ptr_reg] <= cap_entry;
        end
    end

    // Registered read port, addressed by the post-handshake read pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (state_reg == S_DONE) begin
            rd_data_reg <= mem[rd_ptr_next];
        end
    end

    assign bus.state    = state_reg;
    assign bus.count    = count_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;
endmodule

// File: tb/tb_riscv_alu_trace_buffer.sv
// Self-checking bench for riscv_alu_trace_buffer: directed table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_riscv_alu_trace_buffer;
    localparam int XLEN = 32, DEPTH = 16, ALUOP_W = 4;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5*XLEN + ALUOP_W + 6;
    localparam int PC_LSB  = EW - XLEN;
    localparam int RES_LSB = ALUOP_W + 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_alu_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ALUOP_W(ALUOP_W)) bus ();

    riscv_alu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ALUOP_W(ALUOP_W), .POST_MAX(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: buffer contents as a queue, oldest at index 0.
    logic [EW-1:0] q[$];
    int            m_state;   // 0 idle, 1 armed, 2 post, 3 done
    int            m_post;
    bit            m_rdv;

    typedef struct {
        bit          arm;
        bit          cv;
        logic [31:0] res;
        bit          rdy;
        logic [1:0]  exp_state;
        int          exp_count;
        bit          exp_rdv;
        logic [31:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] res, input logic [3:0] op,
                                           input logic rw);
        return {pc, inst, a, b, res, op, inst[11:7], rw};
    endfunction

    function automatic logic [31:0] pc_of(input logic [EW-1:0] e);
        return e[PC_LSB +: XLEN];
    endfunction

    task automatic model_edge();
        bit rdv_before;
        int st_before;
        bit rec;
        bit trig;
        rdv_before = m_rdv;
        st_before  = m_state;
        if (bus.arm) begin
            q.delete();
            m_state = 1;
            m_post  = int'(bus.post_count);
        end else if (m_state == 1 || m_state == 2) begin
            if (bus.cap_valid) begin
                rec = 1'b1;
`ifdef TRACE_REGWRITE_FILTER_EN
                rec = bus.cap_regwr;
`endif
                trig = (bus.trig_pc_en && bus.cap_pc == bus.trig_pc) ||
                       (bus.trig_res_en && bus.cap_result == bus.trig_res);
                if (rec) begin
                    q.push_back(pack(bus.cap_pc, bus.cap_inst, bus.cap_a, bus.cap_b,
                                     bus.cap_result, bus.cap_aluop, bus.cap_regwr));
                    if (q.size() > DEPTH) void'(q.pop_front());
                end
                if (m_state == 1) begin
                    if (trig) m_state = (m_post == 0) ? 3 : 2;
                end else if (rec) begin
                    m_post--;
                    if (m_post == 0) m_state = 3;
                end
            end
        end else if (m_state == 3) begin
            if (rdv_before && bus.rd_ready) void'(q.pop_front());
        end
        m_rdv = (st_before == 3) && (m_state == 3) && (q.size() > 0);
    endtask

    task automatic check_all();
        chk("state", 192'(bus.state), 192'(m_state));
        chk("count", 192'(bus.count), 192'(q.size()));
        chk("rd_valid", 192'(bus.rd_valid), 192'(m_rdv));
        if (m_rdv) chk("rd_data", 192'(bus.rd_data), 192'(q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        bus.cap_valid = 0; bus.cap_pc = 0; bus.cap_inst = 0; bus.cap_a = 0; bus.cap_b = 0;
        bus.cap_result = 0; bus.cap_aluop = 0; bus.cap_regwr = 0; bus.arm = 0; bus.rd_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_state = 0;
        m_post  = 8;
        m_rdv   = 0;
        @(negedge clk);
        check_all();
        chk("reset_rd_data", 192'(bus.rd_data), 192'(0));
    endtask

    task automatic do_arm();
        bus.arm = 1;
        step();
        bus.arm = 0;
    endtask

    task automatic cap(input logic [31:0] pc, input logic [31:0] res, input bit rw);
        bus.cap_valid  = 1;
        bus.cap_pc     = pc;
        bus.cap_inst   = $urandom;
        bus.cap_a      = $urandom;
        bus.cap_b      = $urandom;
        bus.cap_result = res;
        bus.cap_aluop  = 4'($urandom_range(0, 15));
        bus.cap_regwr  = rw;
        step();
        bus.cap_valid  = 0;
    endtask

    task automatic drain(input string name);
        bus.rd_ready = 1;
        for (int i = 0; i < 2*DEPTH + 4 && q.size() > 0; i++) step();
        bus.rd_ready = 0;
        chk({name, "_drained"}, 192'(bus.count), 192'(0));
    endtask

    vec_t vecs[8];
    logic [EW-1:0] held;

    initial begin
        vecs[0] = '{1, 0, 32'h0, 0, 2'b01, 0, 0, 32'h0};
        vecs[1] = '{0, 1, 32'h1, 0, 2'b01, 1, 0, 32'h0};
        vecs[2] = '{0, 1, 32'h2, 0, 2'b01, 2, 0, 32'h0};
        vecs[3] = '{0, 1, 32'h5, 0, 2'b11, 3, 0, 32'h0};
        vecs[4] = '{0, 0, 32'h0, 0, 2'b11, 3, 1, 32'h1};
        vecs[5] = '{0, 0, 32'h0, 1, 2'b11, 2, 1, 32'h2};
        vecs[6] = '{0, 0, 32'h0, 1, 2'b11, 1, 1, 32'h5};
        vecs[7] = '{0, 0, 32'h0, 1, 2'b11, 0, 0, 32'h0};

        bus.trig_pc_en = 0; bus.trig_pc = 0; bus.trig_res_en = 0; bus.trig_res = 0;
        bus.post_count = 0;
        do_reset();

        // 1: wrap with no trigger, then freeze with a late PC trigger.
        do_arm();
        for (int i = 0; i < 20; i++) cap(32'(i*4), 32'(i), 1);
        chk("t1_state", 192'(bus.state), 192'(2'b01));
        chk("t1_count", 192'(bus.count), 192'(16));
        bus.trig_pc_en = 1; bus.trig_pc = 32'h50;
        cap(32'h50, 0, 1);
        step();
        chk("t1_oldest_pc", 192'(pc_of(bus.rd_data)), 192'(32'h14));
        drain("t1");

        // 2: PC trigger with post window of 3.
        bus.trig_pc = 32'h20; bus.post_count = 3;
        do_arm();
        for (int i = 0; i < 16; i++) cap(32'(i*4), 32'(i), 1);
        chk("t2_state", 192'(bus.state), 192'(2'b11));
        chk("t2_count", 192'(bus.count), 192'(12));
        bus.rd_ready = 1;
        for (int k = 0; k < 12; k++) begin
            chk("t2_rd_valid", 192'(bus.rd_valid), 192'(1));
            chk("t2_pc", 192'(pc_of(bus.rd_data)), 192'(k*4));
            step();
        end
        bus.rd_ready = 0;
        chk("t2_end_valid", 192'(bus.rd_valid), 192'(0));

        // 3: result trigger with zero post window, table-driven.
        bus.trig_pc_en = 0; bus.trig_res_en = 1; bus.trig_res = 32'h5; bus.post_count = 0;
        for (int r = 0; r < 8; r++) begin
            bus.arm = vecs[r].arm;
            bus.rd_ready = vecs[r].rdy;
            bus.cap_valid = vecs[r].cv;
            bus.cap_pc = 32'h100 + 32'(r*4);
            bus.cap_inst = $urandom; bus.cap_a = $urandom; bus.cap_b = $urandom;
            bus.cap_result = vecs[r].res;
            bus.cap_aluop = 4'(r); bus.cap_regwr = 1;
            step();
            chk($sformatf("t3_state_r%0d", r), 192'(bus.state), 192'(vecs[r].exp_state));
            chk($sformatf("t3_count_r%0d", r), 192'(bus.count), 192'(vecs[r].exp_count));
            chk($sformatf("t3_rdv_r%0d", r), 192'(bus.rd_valid), 192'(vecs[r].exp_rdv));
            if (vecs[r].exp_rdv)
                chk($sformatf("t3_res_r%0d", r), 192'(bus.rd_data[RES_LSB +: XLEN]), 192'(vecs[r].exp_res));
        end
        clear_inputs();

        // 4: back-to-back readout, then toggling ready.
        bus.trig_res_en = 0; bus.trig_pc_en = 1; bus.trig_pc = 32'h200; bus.post_count = 3;
        do_arm();
        for (int i = 0; i < 4; i++) cap(32'h200 + 32'(i*4), 0, 1);
        step();
        bus.rd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_bubble", 192'(bus.rd_valid), 192'(1));
            chk("t4_pc", 192'(pc_of(bus.rd_data)), 192'(32'h200 + k*4));
            step();
        end
        bus.rd_ready = 0;
        chk("t4_count0", 192'(bus.count), 192'(0));
        do_arm();
        for (int i = 0; i < 4; i++) cap(32'h200 + 32'(i*4), 0, 1);
        step();
        for (int c = 0; c < 16 && q.size() > 0; c++) begin
            bus.rd_ready = (c % 2) == 1;
            held = bus.rd_data;
            step();
            if (c % 2 == 0) chk("t4_stable", 192'(bus.rd_data), 192'(held));
        end
        bus.rd_ready = 0;
        chk("t4_toggle_count", 192'(bus.count), 192'(0));

        // 5: arm colliding with capture and read, then asynchronous reset mid-POST.
        bus.trig_pc_en = 0; bus.post_count = 5;
        do_arm();
        for (int i = 0; i < 3; i++) cap(32'h300 + 32'(i*4), 0, 1);
        bus.arm = 1; bus.rd_ready = 1; bus.cap_valid = 1; bus.cap_pc = 32'h3F0;
        step();
        clear_inputs();
        chk("t5_count", 192'(bus.count), 192'(0));
        chk("t5_state", 192'(bus.state), 192'(2'b01));
        bus.trig_pc_en = 1; bus.trig_pc = 32'h300;
        cap(32'h300, 0, 1);
        cap(32'h304, 0, 1);
        chk("t5_in_post", 192'(bus.state), 192'(2'b10));
        #2 rst = 1'b1;
        #1;
        chk("t5_async_state", 192'(bus.state), 192'(0));
        chk("t5_async_count", 192'(bus.count), 192'(0));
        chk("t5_async_rdv", 192'(bus.rd_valid), 192'(0));
        do_reset();

        // 6: RegWrite filter (or full recording in the default build).
        bus.trig_pc_en = 0; bus.post_count = 0;
        do_arm();
        for (int i = 0; i < 8; i++) cap(32'h400 + 32'(i*4), 0, (i % 2) == 0);
`ifdef TRACE_REGWRITE_FILTER_EN
        chk("t6_count", 192'(bus.count), 192'(4));
`else
        chk("t6_count", 192'(bus.count), 192'(8));
`endif
        bus.trig_pc_en = 1; bus.trig_pc = 32'hFFF0;
        cap(32'hFFF0, 0, 1);
        step();
        bus.rd_ready = 1;
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
`ifdef TRACE_REGWRITE_FILTER_EN
            if (bus.rd_valid) chk("t6_regwr", 192'(bus.rd_data[0]), 192'(1));
`endif
            step();
        end
        bus.rd_ready = 0;

        // Randomized traffic against the model.
        for (int round = 0; round < 40; round++) begin
            bus.trig_pc_en  = $urandom_range(0, 1);
            bus.trig_res_en = $urandom_range(0, 1);
            bus.trig_pc     = 32'($urandom_range(0, 40) * 4);
            bus.trig_res    = 32'($urandom_range(0, 15));
            bus.post_count  = AW'($urandom_range(0, DEPTH-1));
            do_arm();
            for (int c = 0; c < 50; c++) begin
                bus.arm        = ($urandom_range(0, 49) == 0);
                bus.cap_valid  = $urandom_range(0, 1);
                bus.cap_pc     = 32'($urandom_range(0, 40) * 4);
                bus.cap_inst   = $urandom;
                bus.cap_a      = $urandom;
                bus.cap_b      = $urandom;
                bus.cap_result = 32'($urandom_range(0, 15));
                bus.cap_aluop  = 4'($urandom_range(0, 15));
                bus.cap_regwr  = $urandom_range(0, 1);
                bus.rd_ready   = $urandom_range(0, 1);
                step();
            end
            clear_inputs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
